// File: rtl/mem_bus_arbiter_if.sv
// Request/response bundle shared by the arbiter's requester ports and its
// memory bus side; bus_* modports drop the ready line the bus does not use.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              memread;
    logic              memwrite;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              ready;

    modport master (
        output memread, memwrite, addr, writedata,
        input  readdata, ready
    );

    modport slave (
        input  memread, memwrite, addr, writedata,
        output readdata, ready
    );

    modport bus_master (
        output memread, memwrite, addr, writedata,
        input  readdata
    );

    modport bus_slave (
        input  memread, memwrite, addr, writedata,
        output readdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester round-robin arbiter for the single memory/MMIO bus.
// Define MEM_ARB_FIXED_PRIO_EN for fixed m0-first priority instead.
module mem_bus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    mem_bus_arbiter_if.slave         m0,
    mem_bus_arbiter_if.slave         m1,
    mem_bus_arbiter_if.bus_master    mem,
    output logic                     owner
);
    localparam int CNT_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              memread_q, memread_d;
    logic              memwrite_q, memwrite_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              ready0_q, ready0_d;
    logic              ready1_q, ready1_d;

    logic              pend0, pend1;
    logic              gnt;
    logic              gnt_wr;

`ifndef MEM_ARB_FIXED_PRIO_EN
    logic              last_q, last_d;
`endif

    assign pend0 = m0.memread | m0.memwrite;
    assign pend1 = m1.memread | m1.memwrite;

    always_comb begin
        gnt = 1'b0;
`ifdef MEM_ARB_FIXED_PRIO_EN
        gnt = ~pend0;
`else
        // On a tie the side that was not served last goes next
        if (pend0 && pend1) begin
            gnt = ~last_q;
        end else begin
            gnt = pend1;
        end
`endif
        gnt_wr = gnt ? m1.memwrite : m0.memwrite;
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        wr_d       = wr_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        memread_d  = 1'b0;
        memwrite_d = 1'b0;
        ready0_d   = 1'b0;
        ready1_d   = 1'b0;
`ifndef MEM_ARB_FIXED_PRIO_EN
        last_d     = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (pend0 || pend1) begin
                    owner_d    = gnt;
                    wr_d       = gnt_wr;
                    addr_d     = gnt ? m1.addr : m0.addr;
                    wdata_d    = gnt ? m1.writedata : m0.writedata;
                    memwrite_d = gnt_wr;
                    memread_d  = ~gnt_wr;
                    // Writes complete in the issue cycle itself
                    ready0_d   = gnt_wr & ~gnt;
                    ready1_d   = gnt_wr & gnt;
`ifndef MEM_ARB_FIXED_PRIO_EN
                    last_d     = gnt;
`endif
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (wr_q) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = CNT_W'(READ_LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (owner_q) begin
                        rdata1_d = mem.readdata;
                        ready1_d = 1'b1;
                    end else begin
                        rdata0_d = mem.readdata;
                        ready0_d = 1'b1;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            wr_q       <= 1'b0;
            cnt_q      <= '0;
            memread_q  <= 1'b0;
            memwrite_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            ready0_q   <= 1'b0;
            ready1_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            memread_q  <= memread_d;
            memwrite_q <= memwrite_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            ready0_q   <= ready0_d;
            ready1_q   <= ready1_d;
        end
    end

`ifndef MEM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign m0.readdata     = rdata0_q;
    assign m0.ready        = ready0_q;
    assign m1.readdata     = rdata1_q;
    assign m1.ready        = ready1_q;
    assign mem.memread     = memread_q;
    assign mem.memwrite    = memwrite_q;
    assign mem.addr        = addr_q;
    assign mem.writedata   = wdata_q;
    assign owner           = owner_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a one-cycle-latency bus model.
// Grant expectations follow MEM_ARB_FIXED_PRIO_EN when it is defined.
module tb_mem_bus_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic owner;
    logic [31:0] rd_q = '0;

    int n_chk = 0;
    int n_err = 0;

    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
    mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    mem_bus_arbiter #(
        .ADDR_W(32),
        .DATA_W(32),
        .READ_LATENCY(1)
    ) dut (
        .clk  (clk),
        .reset(rst_n),
        .m0   (m0_if),
        .m1   (m1_if),
        .mem  (bus_if),
        .owner(owner)
    );

    always #5 clk = ~clk;

    // Memory returns addr ^ key one cycle after the read strobe
    always @(posedge clk) begin
        if (bus_if.memread) rd_q <= bus_if.addr ^ 32'h12345638;
    end
    assign bus_if.readdata = rd_q;
    assign bus_if.ready    = 1'b0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_if.memread   = 1'b0;
        m0_if.memwrite  = 1'b0;
        m0_if.addr      = '0;
        m0_if.writedata = '0;
        m1_if.memread   = 1'b0;
        m1_if.memwrite  = 1'b0;
        m1_if.addr      = '0;
        m1_if.writedata = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int g;
        int r0;
        int r1;
        logic [31:0] exp_own;
        logic [31:0] exp_dat;

        idle_inputs();
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst memread", bus_if.memread, 0);
        check("rst memwrite", bus_if.memwrite, 0);
        check("rst addr", bus_if.addr, 0);
        check("rst wdata", bus_if.writedata, 0);
        check("rst m0 ready", m0_if.ready, 0);
        check("rst m1 ready", m1_if.ready, 0);
        check("rst m0 rdata", m0_if.readdata, 0);
        check("rst owner", owner, 0);
        rst_n = 1'b1;
        tick();

        // m0 write
        m0_if.memwrite  = 1'b1;
        m0_if.addr      = 32'h1100_0000;
        m0_if.writedata = 32'hDEAD_BEEF;
        tick();
        check("w0 memwrite", bus_if.memwrite, 1);
        check("w0 memread", bus_if.memread, 0);
        check("w0 addr", bus_if.addr, 32'h1100_0000);
        check("w0 wdata", bus_if.writedata, 32'hDEAD_BEEF);
        check("w0 m0 ready", m0_if.ready, 1);
        check("w0 m1 ready", m1_if.ready, 0);
        check("w0 owner", owner, 0);
        idle_inputs();
        tick();
        check("w0 strobe drop", bus_if.memwrite, 0);
        check("w0 ready drop", m0_if.ready, 0);
        check("w0 addr hold", bus_if.addr, 32'h1100_0000);

        // m1 read; address change mid-flight must be ignored
        m1_if.memread = 1'b1;
        m1_if.addr    = 32'h0000_0040;
        tick();
        check("r1 memread", bus_if.memread, 1);
        check("r1 addr", bus_if.addr, 32'h0000_0040);
        check("r1 owner", owner, 1);
        m1_if.addr = 32'h0000_0999;
        tick();
        check("r1 wait strobe", bus_if.memread, 0);
        check("r1 wait ready", m1_if.ready, 0);
        tick();
        check("r1 ready", m1_if.ready, 1);
        check("r1 rdata", m1_if.readdata, 32'h1234_5678);
        check("r1 m0 rdata", m0_if.readdata, 0);
        check("r1 m0 ready", m0_if.ready, 0);
        idle_inputs();
        tick();
        check("r1 ready drop", m1_if.ready, 0);
        check("r1 rdata hold", m1_if.readdata, 32'h1234_5678);

        // Simultaneous writes straight after reset
        do_reset();
        m0_if.memwrite  = 1'b1;
        m0_if.addr      = 32'h0000_0A00;
        m0_if.writedata = 32'h0000_00A0;
        m1_if.memwrite  = 1'b1;
        m1_if.addr      = 32'h0000_0B00;
        m1_if.writedata = 32'h0000_00B1;
        tick();
        check("tie first strobe", bus_if.memwrite, 1);
        check("tie first addr", bus_if.addr, 32'h0000_0A00);
        check("tie first owner", owner, 0);
        check("tie m0 ready", m0_if.ready, 1);
        m0_if.memwrite = 1'b0;
        tick();
        check("tie idle strobe", bus_if.memwrite, 0);
        tick();
        check("tie second strobe", bus_if.memwrite, 1);
        check("tie second addr", bus_if.addr, 32'h0000_0B00);
        check("tie second owner", owner, 1);
        check("tie m1 ready", m1_if.ready, 1);
        m1_if.memwrite = 1'b0;
        tick();

        // Continuous writes from both sides
        m0_if.memwrite  = 1'b1;
        m0_if.writedata = 32'h0000_00A0;
        m1_if.memwrite  = 1'b1;
        m1_if.writedata = 32'h0000_00B1;
        g  = 0;
        r0 = 0;
        r1 = 0;
        for (int c = 0; c < 40 && g < 8; c++) begin
            tick();
            check("one strobe", bus_if.memread & bus_if.memwrite, 0);
            r0 += int'(m0_if.ready);
            r1 += int'(m1_if.ready);
            if (bus_if.memwrite) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                exp_own = 0;
`else
                exp_own = 32'(g % 2);
`endif
                exp_dat = (exp_own == 0) ? 32'h0000_00A0 : 32'h0000_00B1;
                check($sformatf("grant%0d owner", g), owner, exp_own);
                check($sformatf("grant%0d wdata", g), bus_if.writedata, exp_dat);
                g++;
            end
        end
        idle_inputs();
        check("grant count", g, 8);
`ifdef MEM_ARB_FIXED_PRIO_EN
        check("m0 pulses", r0, 8);
        check("m1 pulses", r1, 0);
`else
        check("m0 pulses", r0, 4);
        check("m1 pulses", r1, 4);
`endif
        tick();
        check("rr idle strobe", bus_if.memwrite, 0);

        // Reset during the wait phase of an m0 read
        m0_if.memread = 1'b1;
        m0_if.addr    = 32'h0000_0080;
        tick();
        check("abort issue", bus_if.memread, 1);
        tick();
        rst_n = 1'b0;
        tick();
        check("abort memread", bus_if.memread, 0);
        check("abort memwrite", bus_if.memwrite, 0);
        check("abort addr", bus_if.addr, 0);
        check("abort m0 ready", m0_if.ready, 0);
        check("abort m0 rdata", m0_if.readdata, 0);
        check("abort owner", owner, 0);
        rst_n = 1'b1;
        idle_inputs();
        tick();
        check("abort no ready", m0_if.ready, 0);
        m1_if.memwrite  = 1'b1;
        m1_if.addr      = 32'h0000_0200;
        m1_if.writedata = 32'hCAFE_F00D;
        tick();
        check("post m1 strobe", bus_if.memwrite, 1);
        check("post m1 addr", bus_if.addr, 32'h0000_0200);
        check("post m1 wdata", bus_if.writedata, 32'hCAFE_F00D);
        check("post m1 ready", m1_if.ready, 1);
        check("post owner", owner, 1);
        idle_inputs();
        tick();
        check("post drop", m1_if.ready, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
